// File: rtl/fanin_pkg.sv
// Shared types and constants for the 2:1 packet fan-in arbiter.
package fanin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 64;

  function automatic int cnt_w(input int pkt_max);
    return $clog2(pkt_max + 1);
  endfunction

endpackage

// File: rtl/fanin_rr_pick.sv
// Combinational grant selection: lock owner only, otherwise single requester or rr_ptr.
module fanin_rr_pick
  import fanin_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  state_e     state,
  output logic [1:0] grant,
  output logic       sel
);

  always_comb begin
    grant = 2'b00;
    sel   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
        else              grant = req;
      end
      ST_LOCK0: grant = {1'b0, req[0]};
      ST_LOCK1: grant = {req[1], 1'b0};
      default:  grant = 2'b00;
    endcase
    // Mux select follows the lock owner even when it is momentarily idle
    sel = (state == ST_LOCK1) || ((state == ST_IDLE) && grant[1]);
  end

endmodule

// File: rtl/fanin_arbiter.sv
// 2-to-1 packet-granular fan-in arbiter with a one-entry registered output stage.
// Build option FANIN_FIXED_PRIO_EN: input 0 always wins idle contention.
module fanin_arbiter
  import fanin_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PKT_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_tail,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_tail,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_tail,
  output logic              out_src,
  input  logic              out_ready,
  output logic              lock_err
);

  localparam int CNT_W = cnt_w(PKT_MAX);

  state_e            state, state_nxt;
  logic              rr_ptr;
  logic [1:0]        grant;
  logic              sel;
  logic              can_load;
  logic              accept;
  logic              acc_tail;
  logic [DATA_W-1:0] mux_data;
  logic [CNT_W-1:0]  flit_cnt;

  fanin_rr_pick u_pick (
    .req    ({in1_valid, in0_valid}),
    .rr_ptr (rr_ptr),
    .state  (state),
    .grant  (grant),
    .sel    (sel)
  );

  assign can_load  = !out_valid || out_ready;
  assign in0_ready = !reset && can_load && grant[0];
  assign in1_ready = !reset && can_load && grant[1];
  assign accept    = (in0_valid && in0_ready) || (in1_valid && in1_ready);
  assign acc_tail  = sel ? in1_tail : in0_tail;
  assign mux_data  = sel ? in1_data : in0_data;

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (acc_tail) state_nxt = ST_IDLE;
      else          state_nxt = sel ? ST_LOCK1 : ST_LOCK0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

`ifdef FANIN_FIXED_PRIO_EN
  assign rr_ptr = 1'b0;
`else
  always_ff @(posedge clk) begin
    if (reset)                  rr_ptr <= 1'b0;
    else if (accept && acc_tail) rr_ptr <= ~sel;
  end
`endif

  // Output stage: reload on accept, otherwise empty once drained
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tail  <= 1'b0;
      out_src   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_tail  <= acc_tail;
      out_src   <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Watchdog: flit_cnt holds flits already accepted in this packet, saturating at PKT_MAX
  always_ff @(posedge clk) begin
    if (reset) begin
      flit_cnt <= '0;
      lock_err <= 1'b0;
    end else if (accept) begin
      if (acc_tail) begin
        flit_cnt <= '0;
      end else if (flit_cnt == CNT_W'(PKT_MAX)) begin
        lock_err <= 1'b1;
      end else begin
        flit_cnt <= flit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fanin_arbiter.sv
// Directed self-checking bench for fanin_arbiter (DATA_W=64, PKT_MAX=8).
module tb_fanin_arbiter;

  localparam int DATA_W  = 64;
  localparam int PKT_MAX = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in0_valid, in0_tail, in0_ready;
  logic              in1_valid, in1_tail, in1_ready;
  logic [DATA_W-1:0] in0_data, in1_data, out_data;
  logic              out_valid, out_tail, out_src, out_ready, lock_err;

  int checks = 0;
  int errors = 0;

  fanin_arbiter #(.DATA_W(DATA_W), .PKT_MAX(PKT_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_tail  (in0_tail),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_tail  (in1_tail),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tail  (out_tail),
    .out_src   (out_src),
    .out_ready (out_ready),
    .lock_err  (lock_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Inputs change 1 time unit after a rising edge; #1 lets the ready logic settle
  task automatic drive(input logic v0, input logic [63:0] d0, input logic t0,
                       input logic v1, input logic [63:0] d1, input logic t1,
                       input logic ordy);
    in0_valid = v0; in0_data = d0; in0_tail = t0;
    in1_valid = v1; in1_data = d1; in1_tail = t1;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    int n0, n1;
    logic exp_src;

    reset = 1'b1;
    drive(1, 64'h1, 0, 1, 64'h2, 0, 1);
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_lock_err", lock_err, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc();

    // Three-flit packet from input 0
    drive(1, 64'hA, 0, 0, 0, 0, 1);
    chk("pkt_a_ready", in0_ready, 1);
    cyc();
    chk("pkt_a_valid", out_valid, 1);
    chk("pkt_a_data", out_data, 64'hA);
    chk("pkt_a_src", out_src, 0);
    chk("pkt_a_tail", out_tail, 0);
    drive(1, 64'hB, 0, 0, 0, 0, 1);
    cyc();
    chk("pkt_b_data", out_data, 64'hB);
    chk("pkt_b_tail", out_tail, 0);
    drive(1, 64'hC, 1, 0, 0, 0, 1);
    cyc();
    chk("pkt_c_data", out_data, 64'hC);
    chk("pkt_c_tail", out_tail, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc();
    chk("drain_valid", out_valid, 0);

    // Contention with single-flit packets: rr_ptr=1 after input 0's tail
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin
      exp_src = (i % 2 == 0) ? 1'b1 : 1'b0;
      drive(1, 64'h100 + 64'(n0), 1, 1, 64'h200 + 64'(n1), 1, 1);
      chk($sformatf("rr_in0_ready_%0d", i), in0_ready, !exp_src);
      chk($sformatf("rr_in1_ready_%0d", i), in1_ready, exp_src);
      cyc();
      chk($sformatf("rr_src_%0d", i), out_src, exp_src);
      chk($sformatf("rr_data_%0d", i), out_data,
          exp_src ? 64'h200 + 64'(n1) : 64'h100 + 64'(n0));
      if (exp_src) n1++; else n0++;
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc();

    // Lock hold: input 0 owns the link through its tail, even while idle
    drive(1, 64'hD0, 0, 0, 0, 0, 1);
    chk("lock_start_ready", in0_ready, 1);
    cyc();
    drive(1, 64'hD1, 0, 1, 64'hE, 1, 1);
    chk("lock_in0_ready", in0_ready, 1);
    chk("lock_in1_blk0", in1_ready, 0);
    cyc();
    drive(0, 0, 0, 1, 64'hE, 1, 1);
    chk("lock_in1_blk1", in1_ready, 0);
    cyc();
    chk("lock_gap_valid", out_valid, 0);
    chk("lock_in1_blk2", in1_ready, 0);
    cyc();
    drive(1, 64'hD2, 0, 1, 64'hE, 1, 1);
    chk("lock_in1_blk3", in1_ready, 0);
    cyc();
    chk("lock_d2", out_data, 64'hD2);
    drive(1, 64'hD3, 1, 1, 64'hE, 1, 1);
    chk("lock_in1_blk4", in1_ready, 0);
    cyc();
    chk("lock_d3_tail", out_tail, 1);
    drive(0, 0, 0, 1, 64'hE, 1, 1);
    chk("lock_in1_grant", in1_ready, 1);
    cyc();
    chk("lock_e_data", out_data, 64'hE);
    chk("lock_e_src", out_src, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc();

    // Backpressure: rr_ptr=0, F loads, then output stalls for 5 cycles
    drive(1, 64'hF, 1, 0, 0, 0, 1);
    cyc();
    chk("bp_f_data", out_data, 64'hF);
    for (int i = 0; i < 5; i++) begin
      drive(1, 64'h6, 1, 1, 64'h7, 1, 0);
      chk($sformatf("bp_in0_ready_%0d", i), in0_ready, 0);
      chk($sformatf("bp_in1_ready_%0d", i), in1_ready, 0);
      cyc();
      chk($sformatf("bp_hold_%0d", i), out_data, 64'hF);
      chk($sformatf("bp_valid_%0d", i), out_valid, 1);
    end
    drive(1, 64'h6, 1, 1, 64'h7, 1, 1);
    chk("bp_release_in1", in1_ready, 1);
    cyc();
    chk("bp_h_data", out_data, 64'h7);
    drive(1, 64'h6, 1, 0, 0, 0, 1);
    chk("bp_g_ready", in0_ready, 1);
    cyc();
    chk("bp_g_data", out_data, 64'h6);
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc();
    chk("bp_empty", out_valid, 0);

    // Watchdog: 9 non-tail flits from input 0
    for (int i = 1; i <= 9; i++) begin
      drive(1, 64'(i), 0, 0, 0, 0, 1);
      cyc();
      chk($sformatf("wd_data_%0d", i), out_data, 64'(i));
      if (i == 8) chk("wd_err_at8", lock_err, 0);
      if (i == 9) chk("wd_err_at9", lock_err, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc(); cyc();
    chk("wd_err_sticky", lock_err, 1);
    drive(0, 0, 0, 1, 64'h55, 1, 1);
    chk("wd_lock_blocks_in1", in1_ready, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("wd_rst_valid", out_valid, 0);
    chk("wd_rst_err", lock_err, 0);
    drive(0, 0, 0, 1, 64'h55, 1, 1);
    chk("wd_rst_idle_in1", in1_ready, 1);
    cyc();
    chk("wd_rst_data", out_data, 64'h55);

`ifdef FANIN_FIXED_PRIO_EN
    // Fixed priority: input 0 always wins
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'h300 + 64'(i), 1, 1, 64'h400, 1, 1);
      chk($sformatf("fp_in0_%0d", i), in0_ready, 1);
      chk($sformatf("fp_in1_%0d", i), in1_ready, 0);
      cyc();
      chk($sformatf("fp_src_%0d", i), out_src, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fanin_arbiter.md
Name: fanin_arbiter

Overview:
- 2-to-1 fan-in arbiter for the hierarchical ring. Shares one output link between two flit sources.
- Round-robin selection at packet granularity: the grant is held from the first flit through the tail flit.
- Drives the select of the 2:1 data mux internally and registers the result into a one-entry output stage with a valid/ready handshake.
- Sits in front of ring injection and bridge output ports.

Parameters:
- DATA_W, 64, flit payload width in bits (tail flag carried separately).
- PKT_MAX, 8, maximum flits per packet; used only by the lock watchdog.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in0_valid  input  1  source 0 flit valid.
- in0_data  input  DATA_W  source 0 flit.
- in0_tail  input  1  source 0 flit is the last flit of its packet.
- in0_ready  output  1  source 0 flit accepted this cycle.
- in1_valid  input  1  source 1 flit valid.
- in1_data  input  DATA_W  source 1 flit.
- in1_tail  input  1  source 1 flit is the last flit of its packet.
- in1_ready  output  1  source 1 flit accepted this cycle.
- out_valid  output  1  output register holds a flit.
- out_data  output  DATA_W  registered flit.
- out_tail  output  1  registered tail flag.
- out_src  output  1  source index of the registered flit.
- out_ready  input  1  downstream accepts the flit.
- lock_err  output  1  sticky: a packet exceeded PKT_MAX flits.

Behaviour:
- Reset (synchronous, sampled on the clk rising edge while reset=1):
  - state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_tail=0, out_src=0, lock_err=0, flit counter=0.
  - in0_ready=in1_ready=0 while reset is high.
- Reset mid-packet: the lock is abandoned and the output register is flushed. Upstream must also reset.
- Stage free: can_load = !out_valid | out_ready (combinational).
- States:
  - IDLE: no packet locked. Grant goes to the only valid input. If both are valid, grant goes to rr_ptr.
  - LOCK0 / LOCK1: packet from input 0 / 1 in progress. Only that input may be granted; the other input's ready=0 even if the lock owner is idle.
- Transitions, on an accepted flit (inX_valid & inX_ready):
  - Non-tail flit, from IDLE → LOCKX.
  - Tail flit from IDLE: a single-flit packet; stay in IDLE.
  - Tail flit in LOCKX → IDLE.
  - Every tail accept sets rr_ptr = ~X.
- Ready: inX_ready = can_load & granted(X). This is combinational from valid, state and out_ready. There is no combinational path from inX_data.
- Load: on accept, the output register takes the muxed data, tail and src on the next edge.
- Latency: exactly 1 cycle from input accept to out_valid.
- Throughput: 1 flit/cycle when out_ready is held at 1.
- Backpressure: out_valid=1 & out_ready=0 holds out_* stable and forces both readies to 0.
- Out drained with no accept: out_valid → 0.
- Simultaneous drain and accept: the register reloads and out_valid stays 1 (no bubble).
- Idle lock: a locked input with valid=0 keeps the lock; no timeout on grant.
- Watchdog: counts flits in the current packet. Accepting flit PKT_MAX+1 without a tail sets lock_err, which stays set until reset. Data flow is unaffected.
- rr_ptr changes only on tail accept. It does not change on single-requester grants that end mid-packet.

Optional Feature:
- Macro: FANIN_FIXED_PRIO_EN.
- Defined: rr_ptr is tied to 0, so input 0 always wins IDLE contention. Packet locking is unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Package fanin_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_LOCK0=2'd1, ST_LOCK1=2'd2;
  - default DATA_W;
  - flit counter width function clog2(PKT_MAX+1).
- One sub-module: fanin_rr_pick. It is combinational, takes req[1:0], rr_ptr and the lock state, and outputs a one-hot grant and sel. The data mux and output register stay in fanin_arbiter.

Test Plan:
- Reset then single source: in0 sends a 3-flit packet (A,B,C tail), out_ready=1 → out shows A,B,C on cycles 1-3 after accept, out_src=0, out_tail only on C.
- Contention with rr: both valid, single-flit packets, out_ready=1 → grants alternate 0,1,0,1; rr_ptr toggles on each tail.
- Lock hold: in0 starts a 4-flit packet; in1 valid throughout; in0 drops valid for 2 cycles mid-packet → in1_ready stays 0 until in0 tail accepted, then in1 granted next cycle.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_data stable, both readies 0; then out_ready=1 → no flit lost or duplicated.
- Watchdog: PKT_MAX=8, send 9 non-tail flits → lock_err=1 after 9th accept; remains 1 until reset; reset mid-lock → state IDLE, out_valid=0 next cycle.
- FANIN_FIXED_PRIO_EN defined: both sources streaming single-flit packets → input 0 always granted, in1 starves.
